// File: rtl/nf10_axis_pkg.sv
// Shared AXI-Stream definitions for the NF10 RX path: write-FSM state
// encoding, default data width and the stored beat word layout.
package nf10_axis_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WRITE   = 2'd1,
        ST_DISCARD = 2'd2
    } wr_state_t;

    localparam int unsigned AXIS_DATA_WIDTH_DEFAULT = 64;

    // Stored beat word is {tlast, tstrb, tdata}.
    function automatic int unsigned beat_width(input int unsigned data_width);
        return 1 + data_width / 8 + data_width;
    endfunction

    localparam int unsigned AXIS_BEAT_WIDTH_DEFAULT = beat_width(AXIS_DATA_WIDTH_DEFAULT);

    typedef struct packed {
        logic                                 tlast;
        logic [AXIS_DATA_WIDTH_DEFAULT/8-1:0] tstrb;
        logic [AXIS_DATA_WIDTH_DEFAULT-1:0]   tdata;
    } axis_beat_t;

endpackage

// File: rtl/nf10_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// Written without reset so it maps onto block RAM.
module nf10_sdp_ram #(
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned DATA_WIDTH = 73
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [0:(1 << ADDR_WIDTH)-1];

    // Write port plus one-cycle-latency registered read port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/nf10_rx_err_drop_fifo.sv
// Store-and-forward RX packet FIFO. Frames are written speculatively and
// only become visible downstream once committed by a clean tlast; errored
// or overflowing frames are rewound away.
// Optional build macro: NF10_RX_DROP_STATS_EN enables the frame counters.
module nf10_rx_err_drop_fifo
    import nf10_axis_pkg::*;
#(
    parameter int unsigned C_AXIS_DATA_WIDTH = AXIS_DATA_WIDTH_DEFAULT,
    parameter int unsigned C_ADDR_WIDTH      = 9
) (
    input  logic                           axi_aclk,
    input  logic                           axi_resetn,
    input  logic [C_AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0] s_axis_tstrb,
    input  logic                           s_axis_tvalid,
    output logic                           s_axis_tready,
    input  logic                           s_axis_tlast,
    input  logic                           s_axis_err_tvalid,
    output logic [C_AXIS_DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [C_AXIS_DATA_WIDTH/8-1:0] m_axis_tstrb,
    output logic                           m_axis_tvalid,
    input  logic                           m_axis_tready,
    output logic                           m_axis_tlast,
    output logic [31:0]                    stat_good,
    output logic [31:0]                    stat_drop_err,
    output logic [31:0]                    stat_drop_ovf
);

    localparam int unsigned BEAT_WIDTH = beat_width(C_AXIS_DATA_WIDTH);
    localparam logic [C_ADDR_WIDTH:0] DEPTH = {1'b1, {C_ADDR_WIDTH{1'b0}}};

    typedef logic [C_ADDR_WIDTH:0] ptr_t;

    wr_state_t             state;
    ptr_t                  wr_ptr, commit_ptr, rd_ptr;
    logic                  s_ready;
    logic                  full, accept, dropping;
    logic                  ev_good, ev_err, ev_ovf;
    logic                  ram_we, ram_re, ram_valid;
    logic [BEAT_WIDTH-1:0] ram_rdata;
    logic                  pop;
    logic [1:0]            occ;
    logic [BEAT_WIDTH-1:0] head, spare;
    logic                  head_valid, spare_valid;

    // Classify each accepted input beat: write, discard, commit or rewind.
    always_comb begin
        full     = (ptr_t'(wr_ptr - rd_ptr) == DEPTH);
        accept   = s_axis_tvalid && s_ready;
        dropping = (state == ST_DISCARD) || full;
        ev_ovf   = accept && s_axis_tlast && dropping;
        ev_err   = accept && s_axis_tlast && !dropping && s_axis_err_tvalid;
        ram_we   = accept && !dropping && !(s_axis_tlast && s_axis_err_tvalid);
        ev_good  = ram_we && s_axis_tlast;
    end

    // Write FSM: speculative wr_ptr, commit on clean tlast, rewind on drop.
    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            state      <= ST_IDLE;
            wr_ptr     <= '0;
            commit_ptr <= '0;
            s_ready    <= 1'b0;
        end else begin
            s_ready <= 1'b1;
            if (ev_ovf || ev_err) begin
                wr_ptr <= commit_ptr;
                state  <= ST_IDLE;
            end else if (ev_good) begin
                wr_ptr     <= wr_ptr + 1'b1;
                commit_ptr <= wr_ptr + 1'b1;
                state      <= ST_IDLE;
            end else if (ram_we) begin
                wr_ptr <= wr_ptr + 1'b1;
                state  <= ST_WRITE;
            end else if (accept) begin
                state <= ST_DISCARD;
            end
        end
    end

    nf10_sdp_ram #(
        .ADDR_WIDTH(C_ADDR_WIDTH),
        .DATA_WIDTH(BEAT_WIDTH)
    ) u_ram (
        .clk  (axi_aclk),
        .we   (ram_we),
        .waddr(wr_ptr[C_ADDR_WIDTH-1:0]),
        .wdata({s_axis_tlast, s_axis_tstrb, s_axis_tdata}),
        .re   (ram_re),
        .raddr(rd_ptr[C_ADDR_WIDTH-1:0]),
        .rdata(ram_rdata)
    );

    // Issue a RAM read only when the skid pair is guaranteed room for the
    // result one cycle later: beats held + beat in flight - beat leaving < 2.
    always_comb begin
        pop    = head_valid && m_axis_tready;
        occ    = 2'(head_valid) + 2'(spare_valid) + 2'(ram_valid) - 2'(pop);
        ram_re = (rd_ptr != commit_ptr) && (occ < 2'd2);
    end

    // Read pointer and RAM-output-valid tracking.
    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            rd_ptr    <= '0;
            ram_valid <= 1'b0;
        end else begin
            ram_valid <= ram_re;
            if (ram_re) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Two-entry skid: head drives the output, spare absorbs the beat that
    // lands while the head is stalled; head only changes on pop or when empty.
    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            head        <= '0;
            spare       <= '0;
            head_valid  <= 1'b0;
            spare_valid <= 1'b0;
        end else if (pop) begin
            if (spare_valid) begin
                head        <= spare;
                spare_valid <= ram_valid;
                if (ram_valid) begin
                    spare <= ram_rdata;
                end
            end else begin
                head_valid <= ram_valid;
                if (ram_valid) begin
                    head <= ram_rdata;
                end
            end
        end else if (ram_valid) begin
            if (!head_valid) begin
                head       <= ram_rdata;
                head_valid <= 1'b1;
            end else begin
                spare       <= ram_rdata;
                spare_valid <= 1'b1;
            end
        end
    end

    assign s_axis_tready = s_ready;
    assign m_axis_tvalid = head_valid;
    assign {m_axis_tlast, m_axis_tstrb, m_axis_tdata} = head;

`ifdef NF10_RX_DROP_STATS_EN
    logic [31:0] cnt_good, cnt_err, cnt_ovf;

    // Frame outcome counters, wrapping modulo 2^32.
    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            cnt_good <= '0;
            cnt_err  <= '0;
            cnt_ovf  <= '0;
        end else begin
            if (ev_good) cnt_good <= cnt_good + 32'd1;
            if (ev_err)  cnt_err  <= cnt_err + 32'd1;
            if (ev_ovf)  cnt_ovf  <= cnt_ovf + 32'd1;
        end
    end

    assign stat_good     = cnt_good;
    assign stat_drop_err = cnt_err;
    assign stat_drop_ovf = cnt_ovf;
`else
    assign stat_good     = '0;
    assign stat_drop_err = '0;
    assign stat_drop_ovf = '0;
`endif

endmodule

// File: tb/tb_nf10_rx_err_drop_fifo.sv
// Scoreboard bench for nf10_rx_err_drop_fifo (16-beat buffer instance).
// Frame fate comes from a frame-level model: a frame is dropped as overflow
// when it is longer than the free space, otherwise as error if flagged.
module tb_nf10_rx_err_drop_fifo;

    localparam int unsigned AW    = 4;
    localparam int unsigned DEPTH = 1 << AW;

    typedef logic [72:0] beat_t;
    typedef enum {F_GOOD, F_ERR, F_OVF} fate_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] s_tdata = '0;
    logic [7:0]  s_tstrb = '0;
    logic        s_tvalid = 1'b0;
    logic        s_tlast = 1'b0;
    logic        s_err = 1'b0;
    logic        s_tready;
    logic [63:0] m_tdata;
    logic [7:0]  m_tstrb;
    logic        m_tvalid;
    logic        m_tlast;
    logic        m_tready = 1'b1;
    logic [31:0] stat_good, stat_drop_err, stat_drop_ovf;

    beat_t       exp_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] exp_good = '0, exp_err = '0, exp_ovf = '0;
    logic        held = 1'b0;
    beat_t       held_beat = '0;
    bit          rand_done;

    always #5 clk = ~clk;

    nf10_rx_err_drop_fifo #(
        .C_AXIS_DATA_WIDTH(64),
        .C_ADDR_WIDTH(AW)
    ) dut (
        .axi_aclk         (clk),
        .axi_resetn       (rst_n),
        .s_axis_tdata     (s_tdata),
        .s_axis_tstrb     (s_tstrb),
        .s_axis_tvalid    (s_tvalid),
        .s_axis_tready    (s_tready),
        .s_axis_tlast     (s_tlast),
        .s_axis_err_tvalid(s_err),
        .m_axis_tdata     (m_tdata),
        .m_axis_tstrb     (m_tstrb),
        .m_axis_tvalid    (m_tvalid),
        .m_axis_tready    (m_tready),
        .m_axis_tlast     (m_tlast),
        .stat_good        (stat_good),
        .stat_drop_err    (stat_drop_err),
        .stat_drop_ovf    (stat_drop_ovf)
    );

    task automatic chk(input string name, input beat_t act, input beat_t want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, want, $time);
        end
    endtask

    function automatic beat_t z(input logic [63:0] v);
        return {9'd0, v};
    endfunction

    function automatic fate_t frame_fate(input int unsigned len, input bit err,
                                         input int unsigned free_slots);
        if (len > free_slots) return F_OVF;
        if (err) return F_ERR;
        return F_GOOD;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard on each handshake and checks that a
    // stalled beat is held unchanged until accepted.
    always @(negedge clk) begin : monitor
        beat_t cur;
        cur = {m_tlast, m_tstrb, m_tdata};
        if (!rst_n) begin
            held = 1'b0;
        end else begin
            if (held) begin
                chk("stall_valid", z({63'd0, m_tvalid}), z(64'd1));
                chk("stall_beat", cur, held_beat);
            end
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got %h, expected no beat (t=%0t)", cur, $time);
                end else begin
                    chk("beat", cur, exp_q.pop_front());
                end
                held = 1'b0;
            end else if (m_tvalid) begin
                held      = 1'b1;
                held_beat = cur;
            end else begin
                held = 1'b0;
            end
        end
    end

    task automatic send_frame(input int unsigned len, input bit err, input logic [7:0] last_strb,
                              input int unsigned free_slots, input int unsigned gap_pct);
        fate_t f;
        beat_t beats[$];
        f = frame_fate(len, err, free_slots);
        for (int unsigned i = 0; i < len; i++) begin
            logic [63:0] d;
            logic [7:0]  sb;
            logic        last;
            last = (i == len - 1);
            d    = {$urandom, $urandom};
            sb   = last ? last_strb : 8'($urandom);
            beats.push_back({last, sb, d});
        end
        case (f)
            F_GOOD: begin
                foreach (beats[i]) exp_q.push_back(beats[i]);
                exp_good++;
            end
            F_ERR:   exp_err++;
            default: exp_ovf++;
        endcase
        foreach (beats[i]) begin
            if (gap_pct != 0 && $urandom_range(0, 99) < gap_pct) begin
                s_tvalid = 1'b0;
                tick();
            end
            s_tvalid = 1'b1;
            {s_tlast, s_tstrb, s_tdata} = beats[i];
            s_err = s_tlast ? err : 1'($urandom_range(0, 1));
            tick();
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_err    = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int cyc;
        cyc = 0;
        m_tready = 1'b1;
        while ((exp_q.size() != 0 || m_tvalid) && cyc < 2000) begin
            tick();
            cyc++;
        end
        n_checks++;
        if (cyc >= 2000) begin
            n_fail++;
            $display("FAIL drain_%s: %0d beats still outstanding, expected 0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (6) tick();
    endtask

    task automatic chk_stats(input string tag);
`ifdef NF10_RX_DROP_STATS_EN
        chk({tag, "_stat_good"}, z({32'd0, stat_good}), z({32'd0, exp_good}));
        chk({tag, "_stat_drop_err"}, z({32'd0, stat_drop_err}), z({32'd0, exp_err}));
        chk({tag, "_stat_drop_ovf"}, z({32'd0, stat_drop_ovf}), z({32'd0, exp_ovf}));
`else
        chk({tag, "_stat_good"}, z({32'd0, stat_good}), z(64'd0));
        chk({tag, "_stat_drop_err"}, z({32'd0, stat_drop_err}), z(64'd0));
        chk({tag, "_stat_drop_ovf"}, z({32'd0, stat_drop_ovf}), z(64'd0));
`endif
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_s_tready"}, z({63'd0, s_tready}), z(64'd0));
        chk({tag, "_m_tvalid"}, z({63'd0, m_tvalid}), z(64'd0));
        chk({tag, "_m_tlast"}, z({63'd0, m_tlast}), z(64'd0));
        chk({tag, "_m_tdata"}, z(m_tdata), z(64'd0));
        chk({tag, "_m_tstrb"}, z({56'd0, m_tstrb}), z(64'd0));
        chk({tag, "_stat_good"}, z({32'd0, stat_good}), z(64'd0));
        chk({tag, "_stat_drop_err"}, z({32'd0, stat_drop_err}), z(64'd0));
        chk({tag, "_stat_drop_ovf"}, z({32'd0, stat_drop_ovf}), z(64'd0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Power-on reset and release timing of s_axis_tready.
        rst_n = 1'b0;
        #2;
        chk_reset("por");
        repeat (3) tick();
        rst_n = 1'b1;
        #1;
        chk("tready_at_release", z({63'd0, s_tready}), z(64'd0));
        tick();
        chk("tready_after_edge", z({63'd0, s_tready}), z(64'd1));

        // Three good 8-beat frames back to back.
        m_tready = 1'b1;
        for (int i = 0; i < 3; i++) send_frame(8, 1'b0, 8'hFF, DEPTH, 0);
        wait_drain("t1");
        chk_stats("t1");

        // Errored 8-beat frame followed by a good 4-beat frame.
        send_frame(8, 1'b1, 8'hFF, DEPTH, 0);
        send_frame(4, 1'b0, 8'h07, DEPTH, 0);
        wait_drain("t2");
        chk_stats("t2");

        // Overflow with output stalled: 20-beat dropped, 4-beat forwarded.
        m_tready = 1'b0;
        send_frame(20, 1'b0, 8'hFF, DEPTH, 0);
        send_frame(4, 1'b0, 8'hFF, DEPTH, 0);
        repeat (5) tick();
        chk("t3_head_valid_stalled", z({63'd0, m_tvalid}), z(64'd1));
        wait_drain("t3");
        chk_stats("t3");

        // Capacity boundary: exactly DEPTH fits; DEPTH+1 errored counts as overflow.
        m_tready = 1'b0;
        send_frame(DEPTH, 1'b0, 8'hFF, DEPTH, 0);
        repeat (4) tick();
        wait_drain("t3b");
        m_tready = 1'b0;
        send_frame(DEPTH + 1, 1'b1, 8'hFF, DEPTH, 0);
        send_frame(DEPTH, 1'b1, 8'hFF, DEPTH, 0);
        wait_drain("t3c");
        chk_stats("t3c");

        // Single-beat frames: good with partial strobe, then errored.
        send_frame(1, 1'b0, 8'h0F, DEPTH, 0);
        send_frame(1, 1'b1, 8'hF0, DEPTH, 0);
        wait_drain("t4");
        chk_stats("t4");

        // Random frames with random downstream backpressure and input gaps.
        rand_done = 1'b0;
        fork
            begin
                for (int n = 0; n < 100; n++) begin
                    int unsigned len;
                    int cyc;
                    len = $urandom_range(1, 12);
                    cyc = 0;
                    while (exp_q.size() + len > DEPTH && cyc < 2000) begin
                        tick();
                        cyc++;
                    end
                    if (cyc >= 2000) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL t5_room: %0d beats outstanding, needed %0d free", exp_q.size(), len);
                    end
                    send_frame(len, ($urandom_range(0, 9) == 0), 8'($urandom_range(1, 255)), DEPTH, 20);
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    tick();
                    m_tready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        wait_drain("t5");
        chk_stats("t5");

        // Reset mid-frame with a committed beat stalled at the output.
        m_tready = 1'b0;
        send_frame(4, 1'b0, 8'hFF, DEPTH, 0);
        repeat (4) tick();
        chk("t6_pre_reset_valid", z({63'd0, m_tvalid}), z(64'd1));
        for (int i = 0; i < 3; i++) begin
            s_tvalid = 1'b1;
            s_tlast  = 1'b0;
            s_tstrb  = 8'hFF;
            s_tdata  = {$urandom, $urandom};
            tick();
        end
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        exp_good = '0;
        exp_err  = '0;
        exp_ovf  = '0;
        chk_reset("t6_assert");
        repeat (3) begin
            tick();
            chk_reset("t6_hold");
        end
        s_tvalid = 1'b0;
        rst_n = 1'b1;
        tick();
        m_tready = 1'b1;
        send_frame(2, 1'b0, 8'h3C, DEPTH, 0);
        wait_drain("t6");
        chk_stats("t6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
